// File: rtl/booth_wallace_mul_pipe_pkg.sv
// Shared types and constant helpers for the Booth/Wallace multiplier:
// Booth select encoding, partial-product count and Wallace layer sizing.
package booth_wallace_mul_pipe_pkg;

  typedef enum logic [2:0] {
    BoothZero = 3'd0,
    BoothPos1 = 3'd1,
    BoothPos2 = 3'd2,
    BoothNeg1 = 3'd3,
    BoothNeg2 = 3'd4
  } booth_sel_e;

  function automatic int unsigned pp_num(int unsigned w);
    return w / 2 + 1;
  endfunction

  // Group is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_e booth_decode(logic [2:0] grp);
    booth_sel_e sel;
    unique case (grp)
      3'b000, 3'b111: sel = BoothZero;
      3'b001, 3'b010: sel = BoothPos1;
      3'b011:         sel = BoothPos2;
      3'b100:         sel = BoothNeg2;
      3'b101, 3'b110: sel = BoothNeg1;
      default:        sel = BoothZero;
    endcase
    return sel;
  endfunction

  // Rows left after one 3:2 layer: each full triple becomes two rows, leftovers pass through.
  function automatic int unsigned wallace_next(int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned wallace_layers(int unsigned n0);
    int unsigned n;
    int unsigned l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = wallace_next(n);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_wallace_mul_pipe_if.sv
// Request/response bundle of the multiplier: input handshake, flush and product handshake.
interface booth_wallace_mul_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

  modport master (
    output in_valid, in_signed, in_a, in_b, flush, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, flush, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/booth_wallace_mul_pipe_pp_gen.sv
// One radix-4 Booth partial product, sign-extended to 2*WIDTH and not yet shifted.
// Negative selects return the one's complement; neg_o carries the +1 correction.
module booth_wallace_mul_pipe_pp_gen
  import booth_wallace_mul_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH+1:0]   a_ext_i,
  input  logic [2:0]         group_i,
  output logic [2*WIDTH-1:0] pp_o,
  output logic               neg_o
);
  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0] a_w;
  logic [W2-1:0] a2_w;
  booth_sel_e    sel;

  assign a_w  = {{(W2 - WIDTH - 2){a_ext_i[WIDTH+1]}}, a_ext_i};
  assign a2_w = {a_w[W2-2:0], 1'b0};
  assign sel  = booth_decode(group_i);

  always_comb begin
    pp_o  = '0;
    neg_o = 1'b0;
    unique case (sel)
      BoothZero: pp_o = '0;
      BoothPos1: pp_o = a_w;
      BoothPos2: pp_o = a2_w;
      BoothNeg1: begin
        pp_o  = ~a_w;
        neg_o = 1'b1;
      end
      BoothNeg2: begin
        pp_o  = ~a2_w;
        neg_o = 1'b1;
      end
      default:   pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Two-stage pipelined signed/unsigned multiplier: Booth partial products and Wallace
// reduction into stage 1, carry-propagate add into stage 2, valid/ready with flush.
module booth_wallace_mul_pipe
  import booth_wallace_mul_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic                     clk,
  input logic                     resetn,
  booth_wallace_mul_pipe_if.slave bus_io
);
  localparam int unsigned PP_NUM    = pp_num(WIDTH);
  localparam int unsigned W2        = 2 * WIDTH;
  localparam int unsigned NumRows   = PP_NUM + 1;
  localparam int unsigned NumLayers = wallace_layers(NumRows);

  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] b_ext;
  logic [WIDTH+2:0] b_grp;
  logic [W2-1:0]    pp [PP_NUM];
  logic [PP_NUM-1:0] neg;
  logic [W2-1:0]    corr;
  logic [W2-1:0]    tree [NumLayers+1][NumRows];

  assign a_ext = {{2{bus_io.in_signed & bus_io.in_a[WIDTH-1]}}, bus_io.in_a};
  assign b_ext = {{2{bus_io.in_signed & bus_io.in_b[WIDTH-1]}}, bus_io.in_b};
  // Bit 0 is the implicit b[-1] = 0, so group i sits at b_grp[2i+2:2i].
  assign b_grp = {b_ext, 1'b0};

  for (genvar i = 0; i < PP_NUM; i++) begin : g_pp
    logic [W2-1:0] pp_raw;

    booth_wallace_mul_pipe_pp_gen #(
      .WIDTH (WIDTH)
    ) u_pp_gen (
      .a_ext_i (a_ext),
      .group_i (b_grp[2*i+2:2*i]),
      .pp_o    (pp_raw),
      .neg_o   (neg[i])
    );

    assign pp[i] = pp_raw << (2 * i);
  end

  always_comb begin
    corr = '0;
    for (int unsigned i = 0; i < PP_NUM; i++) begin
      corr[2*i] = neg[i];
    end
  end

  // Wallace tree: each layer compresses row triples with 3:2 full adders column-wise.
  always_comb begin
    int unsigned n;
    int unsigned grp;
    logic [W2-1:0] x;
    logic [W2-1:0] y;
    logic [W2-1:0] z;
    x   = '0;
    y   = '0;
    z   = '0;
    grp = 0;
    for (int unsigned l = 0; l <= NumLayers; l++) begin
      for (int unsigned r = 0; r < NumRows; r++) begin
        tree[l][r] = '0;
      end
    end
    for (int unsigned r = 0; r < PP_NUM; r++) begin
      tree[0][r] = pp[r];
    end
    tree[0][PP_NUM] = corr;
    n = NumRows;
    for (int unsigned l = 1; l <= NumLayers; l++) begin
      grp = n / 3;
      for (int unsigned g = 0; g < NumRows / 3; g++) begin
        if (g < grp) begin
          x = tree[l-1][3*g];
          y = tree[l-1][3*g+1];
          z = tree[l-1][3*g+2];
          tree[l][2*g]   = x ^ y ^ z;
          tree[l][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (r < n % 3) begin
          tree[l][2*grp+r] = tree[l-1][3*grp+r];
        end
      end
      n = 2 * grp + n % 3;
    end
  end

  logic          s1_valid_q, s1_valid_d;
  logic [W2-1:0] s1_sum_q, s1_sum_d;
  logic [W2-1:0] s1_carry_q, s1_carry_d;
  logic          s2_valid_q, s2_valid_d;
  logic [W2-1:0] prod_q, prod_d;
  logic          s1_adv, s2_adv, accept;

  assign s2_adv          = ~s2_valid_q | bus_io.out_ready;
  assign s1_adv          = ~s1_valid_q | s2_adv;
  assign bus_io.in_ready = resetn & ~bus_io.flush & s1_adv;
  assign accept          = bus_io.in_valid & bus_io.in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_carry_d = s1_carry_q;
    s2_valid_d = s2_valid_q;
    prod_d     = prod_q;
    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_sum_d   = tree[NumLayers][0];
      s1_carry_d = tree[NumLayers][1];
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        prod_d = s1_sum_q + s1_carry_q;
      end
    end
    // Data may go stale on flush; only the valid bits are cleared.
    if (bus_io.flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_carry_q <= s1_carry_d;
      s2_valid_q <= s2_valid_d;
      prod_q     <= prod_d;
    end
  end

  assign bus_io.out_valid = s2_valid_q;
  assign bus_io.out_prod  = prod_q;

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Directed and random checks of booth_wallace_mul_pipe at WIDTH=32 using an in-order
// scoreboard of expected products.
module tb_booth_wallace_mul_pipe;
  localparam int unsigned W = 32;
  localparam int unsigned NRand = 10000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  booth_wallace_mul_pipe_if #(.WIDTH(W)) bus ();

  booth_wallace_mul_pipe #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  logic [63:0] cur_exp;
  logic        acc;
  int          run_len;
  int          max_run;
  string       phase;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(logic sgn, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Evaluates this cycle's handshakes against the scoreboard, then crosses one edge.
  task automatic tick();
    #1;
    acc = 1'b0;
    if (bus.out_valid) run_len++;
    else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check_eq({phase, "_spurious"}, 64'(bus.out_valid), 64'd0);
      else check_eq({phase, "_prod"}, bus.out_prod, exp_q.pop_front());
    end
    if (bus.flush) exp_q.delete();
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(cur_exp);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic sgn, logic [31:0] a, logic [31:0] b, logic [63:0] e);
    bus.in_valid  = 1'b1;
    bus.in_signed = sgn;
    bus.in_a      = a;
    bus.in_b      = b;
    cur_exp       = e;
  endtask

  task automatic run_vec(string tag, logic sgn, logic [31:0] a, logic [31:0] b, logic [63:0] e);
    phase = tag;
    bus.out_ready = 1'b1;
    drive(sgn, a, b, e);
    tick();
    check_eq({tag, "_acc"}, 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    check_eq({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    tick();
    check_eq({tag, "_lat2"}, 64'(bus.out_valid), 64'd1);
    tick();
    check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int cyc;
    logic pending;
    logic got;
    logic sgn;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;
    run_len       = 0;
    max_run       = 0;
    phase         = "reset";
    #2;
    check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("reset_out_prod", bus.out_prod, 64'd0);
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check_eq("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    run_vec("u_ones",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_vec("s_ones",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_vec("s_m3x5",   1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
    run_vec("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_vec("u_zero",   1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000);
    run_vec("s_maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run_vec("u_x16",    1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
    run_vec("u_1xones", 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);

    // Back-to-back stream with no backpressure.
    phase = "b2b";
    bus.out_ready = 1'b1;
    run_len = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'(i + 1), 32'hFFFF_FFFF, (64'(i + 1) << 32) - 64'(i + 1));
      check_eq("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_eq("b2b_valid_run", 64'(max_run), 64'd8);
    check_eq("b2b_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: two accepted, third stalls, output held.
    phase = "bp";
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    check_eq("bp_acc0", 64'(acc), 64'd1);
    drive(1'b0, 32'h0000_0006, 32'h0000_0007, 64'h0000_0000_0000_002A);
    tick();
    check_eq("bp_acc1", 64'(acc), 64'd1);
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_hold_prod", bus.out_prod, 64'hFFFF_FFFF_FFFF_FFEB);
      tick();
      check_eq("bp_hold_acc", 64'(acc), 64'd0);
    end
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      tick();
      got = acc;
    end
    check_eq("bp_acc2", 64'(got), 64'd1);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check_eq("bp_drain", 64'(exp_q.size()), 64'd0);

    // Flush with two in flight, consumer stalled: nothing of them may appear.
    phase = "flush";
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd3, 32'd5, 64'h0F);
    tick();
    drive(1'b0, 32'd4, 32'd5, 64'h14);
    tick();
    drive(1'b0, 32'd9, 32'd9, 64'h51);
    bus.flush = 1'b1;
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("flush_out_valid0", 64'(bus.out_valid), 64'd0);
    tick();
    check_eq("flush_out_valid1", 64'(bus.out_valid), 64'd0);
    tick();
    check_eq("flush_out_valid2", 64'(bus.out_valid), 64'd0);
    run_vec("post_flush", 1'b1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);

    // Flush while the output handshake completes: that product still counts.
    phase = "flush_hs";
    drive(1'b0, 32'd10, 32'd10, 64'h64);
    tick();
    drive(1'b0, 32'd11, 32'd11, 64'h79);
    tick();
    check_eq("flush_hs_valid", 64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1;
    drive(1'b0, 32'd12, 32'd12, 64'h90);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_hs_after", 64'(bus.out_valid), 64'd0);
    tick();
    check_eq("flush_hs_after2", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset between edges with results pending.
    phase = "rst";
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd2, 32'd3, 64'h6);
    tick();
    drive(1'b0, 32'd5, 32'd5, 64'h19);
    tick();
    bus.in_valid = 1'b0;
    check_eq("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_prod", bus.out_prod, 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    tick();
    check_eq("rst_idle0", 64'(bus.out_valid), 64'd0);
    tick();
    check_eq("rst_idle1", 64'(bus.out_valid), 64'd0);
    run_vec("post_rst", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001);

    // Random traffic with random backpressure and occasional flush.
    phase   = "rand";
    issued  = 0;
    cyc     = 0;
    pending = 1'b0;
    while ((issued < NRand || pending || exp_q.size() != 0) && cyc < 80000) begin
      bus.out_ready = ($urandom_range(3) != 0);
      bus.flush     = ($urandom_range(49) == 0);
      if (!pending && issued < NRand && $urandom_range(4) != 0) begin
        sgn = 1'($urandom_range(1));
        ra  = pick_op();
        rb  = pick_op();
        drive(sgn, ra, rb, model(sgn, ra, rb));
        pending = 1'b1;
      end
      bus.in_valid = pending;
      tick();
      if (acc) begin
        pending = 1'b0;
        issued++;
      end
      cyc++;
    end
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("rand_issued", 64'(issued), 64'(NRand));
    check_eq("rand_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
